serial_alu: RTL and testbench
=============================

SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 1, meaning bits processed per cycle; WIDTH mod DIGIT SHALL be 0, checked at elaboration.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, meaning request a new operation.
REQ-006 SHALL have port abort, input, 1 bit, meaning cancel the operation in progress.
REQ-007 SHALL have port opcode, input, 3 bits, meaning the operation select.
REQ-008 SHALL have ports A and B, input, WIDTH bits each, meaning the operands.
REQ-009 SHALL have port C, output, WIDTH bits, meaning the registered result.
REQ-010 SHALL have port busy, output, 1 bit, meaning an operation is in progress.
REQ-011 SHALL have port done, output, 1 bit, meaning a one-cycle completion pulse.
REQ-012 SHALL have ports carry_out and zero, output, 1 bit each, meaning the result flags.

Function
REQ-013 Opcodes SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ADD, 111 SUB (A + ~B + 1).
REQ-014 States SHALL be IDLE and RUN; N = WIDTH/DIGIT.
REQ-015 In IDLE with start=1 and abort=0 at an edge, the block SHALL latch A, B and opcode, clear the digit index, load carry (0 for ADD, 1 for SUB, don't-care otherwise), and go to RUN.
REQ-016 While in RUN, busy SHALL be 1; it SHALL be 0 in IDLE.
REQ-017 Each RUN edge SHALL write digit i (bits i*DIGIT .. i*DIGIT+DIGIT-1) of C from the latched operands, update the carry for ADD/SUB, and increment i, LSB digit first.
REQ-018 Digits of C not yet written in the current operation SHALL keep their previous-operation values.
REQ-019 At the edge writing digit N-1, the block SHALL return to IDLE, pulse done=1 for exactly one cycle, and register zero=(final C==0) and carry_out (final carry for ADD/SUB, 0 for logic ops).
REQ-020 Latency SHALL be exactly N edges from the start-accepting edge to done high.
REQ-021 Changes on A, B or opcode during RUN SHALL NOT affect the result.
REQ-022 start during RUN SHALL be ignored and not queued.
REQ-023 abort=1 in RUN SHALL return the block to IDLE at that edge, write no digit, leave the flags unchanged, and not pulse done.
REQ-024 abort SHALL take priority over start; abort in IDLE SHALL have no effect.
REQ-025 carry_out and zero SHALL hold until the next done.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, C=0, busy=0, done=0, carry_out=0, zero=0, digit index 0, and latched operands 0, overriding start and abort.
REQ-027 rst asserted mid-operation SHALL discard the operation with no done pulse.

Structure
REQ-028 Opcode constants and the state encoding SHALL live in the shared package serial_alu_pkg.
REQ-029 Per-digit combinational logic (logic op or DIGIT-bit add with carry in/out) SHALL be the sub-module serial_alu_digit, instantiated once.

Verification
REQ-030 WIDTH=8, DIGIT=1, NAND A=0xF0, B=0xCC -> done 8 cycles after start, C=0x3F, carry_out=0, zero=0.
REQ-031 ADD A=0xFF, B=0x01 -> C=0x00, carry_out=1, zero=1.
REQ-032 SUB A=0x05, B=0x07 -> C=0xFE, carry_out=0 (borrow); SUB 0x07-0x05 -> C=0x02, carry_out=1.
REQ-033 WIDTH=8, DIGIT=4, ADD 0x3C+0x0F -> C=0x4B after 2 cycles; a second start during busy is ignored.
REQ-034 Prior C=0x00, XOR 0xFF^0x00 with abort after 3 RUN edges -> C=0x07, no done, busy=0.
REQ-035 rst pulsed during RUN -> next cycle C=0x00, busy=0, no done; a fresh NAND 0x00,0x00 -> C=0xFF.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the digit-serial ALU: opcode encoding, FSM state
// encoding and a small opcode-classification helper.
package serial_alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // ADD and SUB are the only opcodes that produce a meaningful carry.
    function automatic logic is_arith(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/serial_alu_digit.sv
// One DIGIT-bit slice of the ALU: a bitwise logic op, or an add with carry
// in/out where SUB is formed as A + ~B with the carry preloaded to 1.
module serial_alu_digit
    import serial_alu_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [2:0]       opcode_i,
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             carry_i,
    output logic [DIGIT-1:0] res_o,
    output logic             carry_o
);

    logic [DIGIT:0] sum;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        sum     = '0;
        res_o   = '0;
        carry_o = 1'b0;
        case (opcode_i)
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_NAND: res_o = ~(a_i & b_i);
            OP_NOR:  res_o = ~(a_i | b_i);
            OP_XNOR: res_o = ~(a_i ^ b_i);
            OP_ADD: begin
                sum     = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, carry_i};
                res_o   = sum[DIGIT-1:0];
                carry_o = sum[DIGIT];
            end
            OP_SUB: begin
                sum     = {1'b0, a_i} + {1'b0, ~b_i} + {{DIGIT{1'b0}}, carry_i};
                res_o   = sum[DIGIT-1:0];
                carry_o = sum[DIGIT];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: latches operands on start, then produces DIGIT result
// bits per cycle, LSB digit first, and pulses done with the result flags.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             busy,
    output logic             done,
    output logic             carry_out,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_alu: WIDTH must be a positive multiple of DIGIT");
    end

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic             done_q, done_d, co_q, co_d, zero_q, zero_d;

    logic [DIGIT-1:0] dig_res;
    logic             dig_carry;

    serial_alu_digit #(.DIGIT(DIGIT)) u_digit (
        .opcode_i (op_q),
        .a_i      (a_q[int'(idx_q)*DIGIT +: DIGIT]),
        .b_i      (b_q[int'(idx_q)*DIGIT +: DIGIT]),
        .carry_i  (carry_q),
        .res_o    (dig_res),
        .carry_o  (dig_carry)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        done_d  = 1'b0;
        co_d    = co_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = opcode;
                    idx_d   = '0;
                    carry_d = (opcode == OP_SUB);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort leaves C partially written and the flags untouched.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    c_d[int'(idx_q)*DIGIT +: DIGIT] = dig_res;
                    carry_d = dig_carry;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IW'(N - 1)) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        zero_d  = (c_d == '0);
                        co_d    = is_arith(op_q) ? dig_carry : 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            done_q  <= done_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
        end
    end

    assign C         = c_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign carry_out = co_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: a DIGIT=1 and a DIGIT=4 instance share stimulus and
// are compared each cycle against an arithmetic model of the whole operation.
module tb_serial_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort;
    logic [2:0] opcode;
    logic [7:0] A, B;

    logic [7:0] c_w    [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       co_w   [2];
    logic       z_w    [2];

    serial_alu #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .opcode(opcode),
        .A(A), .B(B), .C(c_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .carry_out(co_w[0]), .zero(z_w[0])
    );

    serial_alu #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .opcode(opcode),
        .A(A), .B(B), .C(c_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .carry_out(co_w[1]), .zero(z_w[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    int lat [2] = '{8, 2};
    int dw  [2] = '{1, 4};

    logic [7:0] exp_c  [2];
    logic       exp_co [2];
    logic       exp_z  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full-width result of one operation; bit 8 is the carry for ADD/SUB.
    function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: return {1'b0, a ^ b};
            3'd3: return {1'b0, ~(a & b)};
            3'd4: return {1'b0, ~(a | b)};
            3'd5: return {1'b0, ~(a ^ b)};
            3'd6: return {1'b0, a} + {1'b0, b};
            default: return {1'b0, a} + {1'b0, ~b} + 9'd1;
        endcase
    endfunction

    task automatic check_all(input string tag, input int i, input logic eb, input logic ed);
        string t;
        t = $sformatf("%s/d%0d", tag, dw[i]);
        check({t, ".C"},    c_w[i],    exp_c[i]);
        check({t, ".co"},   co_w[i],   exp_co[i]);
        check({t, ".zero"}, z_w[i],    exp_z[i]);
        check({t, ".busy"}, busy_w[i], eb);
        check({t, ".done"}, done_w[i], ed);
    endtask

    task automatic scramble();
        A      = 8'($urandom);
        B      = 8'($urandom);
        opcode = 3'($urandom);
    endtask

    // stop_at = RUN edges completed before abort/rst hits (99: never).
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int stop_at, input bit use_rst,
                          input bit extra_start);
        logic [8:0] r;
        bit         alive [2];
        logic [7:0] prior [2];
        logic [7:0] mask;
        r = ref_alu(op, a, b);
        @(negedge clk);
        start = 1'b1; abort = 1'b0; A = a; B = b; opcode = op;
        @(negedge clk);
        start = 1'b0;
        scramble();
        for (int i = 0; i < 2; i++) begin
            alive[i] = 1'b1;
            prior[i] = exp_c[i];
            check_all({tag, "@0"}, i, 1'b1, 1'b0);
        end
        for (int e = 1; e <= 8; e++) begin
            if (e == stop_at + 1) begin
                if (use_rst) rst = 1'b1;
                else         abort = 1'b1;
            end
            if (extra_start && e == 1) start = 1'b1;
            @(negedge clk);
            rst = 1'b0; abort = 1'b0; start = 1'b0;
            scramble();
            for (int i = 0; i < 2; i++) begin
                logic eb, ed;
                eb = 1'b0;
                ed = 1'b0;
                if (use_rst && e == stop_at + 1) begin
                    exp_c[i]  = 8'h00;
                    exp_co[i] = 1'b0;
                    exp_z[i]  = 1'b0;
                    alive[i]  = 1'b0;
                end else if (alive[i]) begin
                    if (e == stop_at + 1) begin
                        alive[i] = 1'b0;
                    end else begin
                        mask = (e * dw[i] >= 8) ? 8'hFF : 8'((1 << (e * dw[i])) - 1);
                        exp_c[i] = (r[7:0] & mask) | (prior[i] & ~mask);
                        if (e == lat[i]) begin
                            ed        = 1'b1;
                            exp_co[i] = r[8];
                            exp_z[i]  = (r[7:0] == 8'h00);
                            alive[i]  = 1'b0;
                        end else begin
                            eb = 1'b1;
                        end
                    end
                end
                check_all($sformatf("%s@%0d", tag, e), i, eb, ed);
            end
        end
    endtask

    // start/abort pulses in IDLE; neither instance may leave IDLE.
    task automatic idle_probe(input string tag, input bit s, input bit ab);
        @(negedge clk);
        start = s; abort = ab;
        scramble();
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 2; i++) check_all(tag, i, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b0; opcode = 3'd0; A = 8'hAA; B = 8'h55;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_c[i] = 8'h00; exp_co[i] = 1'b0; exp_z[i] = 1'b0;
            check_all("reset", i, 1'b0, 1'b0);
        end
        rst = 1'b0; start = 1'b0;

        run_op("xor_abort3", 3'b010, 8'hFF, 8'h00, 3, 1'b0, 1'b0);
        run_op("nand",       3'b011, 8'hF0, 8'hCC, 99, 1'b0, 1'b0);
        run_op("add_ovf",    3'b110, 8'hFF, 8'h01, 99, 1'b0, 1'b0);
        run_op("sub_borrow", 3'b111, 8'h05, 8'h07, 99, 1'b0, 1'b0);
        run_op("sub_pos",    3'b111, 8'h07, 8'h05, 99, 1'b0, 1'b0);
        run_op("add_2start", 3'b110, 8'h3C, 8'h0F, 99, 1'b0, 1'b1);
        run_op("rst_mid",    3'b001, 8'h5A, 8'hA5, 1, 1'b1, 1'b0);
        run_op("nand_zero",  3'b011, 8'h00, 8'h00, 99, 1'b0, 1'b0);
        run_op("abort_0",    3'b110, 8'h81, 8'h7F, 0, 1'b0, 1'b0);
        idle_probe("idle_abort",       1'b0, 1'b1);
        idle_probe("idle_abort_start", 1'b1, 1'b1);

        for (int k = 0; k < 60; k++) begin
            int  r, stop;
            bit  ur;
            r    = $urandom_range(0, 9);
            stop = (r < 6) ? 99 : $urandom_range(0, 7);
            ur   = (r == 9);
            run_op($sformatf("rnd%0d", k), 3'($urandom), 8'($urandom), 8'($urandom),
                   stop, ur, bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
